seq_multiplier: RTL and testbench



---
 rtl/seq_multiplier_pkg.sv | 23 ++
 rtl/mul_step.sv | 25 ++
 rtl/seq_multiplier.sv | 138 +++++++++++++
 tb/tb_seq_multiplier.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_multiplier_pkg.sv
// Shared ALU definitions for the sequential multiplier: default operand
// width, controller state encoding and the step-counter width helper.
package seq_multiplier_pkg;

   // Default operand width; the product is twice this wide.
   localparam int DEF_WIDTH = 16;

   // Controller states: waiting for a request, iterating, writing the result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   // The step counter must be able to hold the value w, hence w+1 codes.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

   // Step-counter width for the default operand width.
   localparam int CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/mul_step.sv
// One shift-add multiplier step: conditionally add the multiplicand to the
// partial accumulator, then shift {sum, mplier} right by one bit so the
// multiplier register gathers the low product bits.
module mul_step
   import seq_multiplier_pkg::*;
#(
   parameter int l = DEF_WIDTH
) (
   input  logic [l:0]   acc,
   input  logic [l-1:0] mplier,
   input  logic [l-1:0] mcand,
   output logic [l:0]   acc_next,
   output logic [l-1:0] mplier_next
);

   logic [l:0] sum;

   // Conditional add (l+1 bits wide, so the carry is kept) followed by the shift.
   always_comb begin
      sum         = acc + (mplier[0] ? {1'b0, mcand} : '0);
      acc_next    = {1'b0, sum[l:1]};
      mplier_next = {sum[0], mplier[l-1:1]};
   end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier producing the full 2l-bit product, one
// multiplier bit per clock, in unsigned or two's-complement mode. Signed
// operands are reduced to magnitudes up front and the sign is reapplied in
// the FIX cycle. Latency is l+1 edges from the accepting edge to done.
module seq_multiplier
   import seq_multiplier_pkg::*;
#(
   parameter int l = DEF_WIDTH
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic           signed_mode,
   input  logic [l-1:0]   A,
   input  logic [l-1:0]   B,
   output logic           busy,
   output logic           done,
   output logic [2*l-1:0] Product,
   output logic           Overflow
);

   localparam int CW = cnt_width(l);

   state_t         state;
   state_t         state_nxt;

   logic           smode;
   logic           neg;
   logic [l-1:0]   mcand;
   logic [l-1:0]   mplier;
   logic [l:0]     acc;
   logic [CW-1:0]  cnt;

   logic [l:0]     acc_step;
   logic [l-1:0]   mplier_step;
   logic [l-1:0]   a_mag;
   logic [l-1:0]   b_mag;
   logic           last_step;
   logic [2*l-1:0] mag;
   logic [2*l-1:0] prod_fix;
   logic           ovf_fix;

   // Single datapath step, reused every RUN cycle.
   mul_step #(
      .l (l)
   ) u_mul_step (
      .acc         (acc),
      .mplier      (mplier),
      .mcand       (mcand),
      .acc_next    (acc_step),
      .mplier_next (mplier_step)
   );

   // Operand magnitudes, result sign correction and overflow detection.
   // The most-negative operand negates to itself, which read as unsigned is
   // exactly its magnitude, so it needs no special handling.
   always_comb begin
      a_mag     = (signed_mode && A[l-1]) ? -A : A;
      b_mag     = (signed_mode && B[l-1]) ? -B : B;
      last_step = (cnt == CW'(l - 1));
      mag       = {acc[l-1:0], mplier};
      prod_fix  = neg ? -mag : mag;
      if (smode) begin
         // Fits in l signed bits only if the top l+1 bits are a sign extension.
         ovf_fix = !((&prod_fix[2*l-1:l-1]) || !(|prod_fix[2*l-1:l-1]));
      end else begin
         ovf_fix = |prod_fix[2*l-1:l];
      end
   end

   // NOTE: every always_comb output gets a default before any branch, so no
   // path leaves it unassigned and no latch is inferred.
   // Next-state logic for the IDLE -> RUN -> FIX controller.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last_step) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Operand capture, per-step iteration and result write-back.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         smode    <= 1'b0;
         neg      <= 1'b0;
         mcand    <= '0;
         mplier   <= '0;
         acc      <= '0;
         cnt      <= '0;
         done     <= 1'b0;
         Product  <= '0;
         Overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  smode  <= signed_mode;
                  neg    <= signed_mode & (A[l-1] ^ B[l-1]);
                  mcand  <= a_mag;
                  mplier <= b_mag;
                  acc    <= '0;
                  cnt    <= '0;
               end
            end
            RUN: begin
               acc    <= acc_step;
               mplier <= mplier_step;
               cnt    <= cnt + CW'(1);
            end
            FIX: begin
               Product  <= prod_fix;
               Overflow <= ovf_fix;
               done     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // busy covers RUN and FIX; the done cycle is already back in IDLE.
   assign busy = (state != IDLE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and randomised checks for seq_multiplier (l = 16): reset values,
// unsigned and signed products, overflow flag, latency, start/busy/done
// handshake, back-to-back operation and asynchronous reset mid-operation.
module tb_seq_multiplier;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        signed_mode;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [31:0] Product;
  logic        Overflow;

  int errors;
  int checks;

  seq_multiplier #(
    .l (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .Product     (Product),
    .Overflow    (Overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input logic ok, input string msg);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL %s", msg);
    end
  endtask

  // Reference model: full-width arithmetic, overflow from the numeric range.
  function automatic logic [32:0] ref_mul(input logic sm, input logic [15:0] a,
                                          input logic [15:0] b);
    logic signed [31:0] sp;
    logic [31:0]        up;
    logic               ov;
    if (sm) begin
      sp = $signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b});
      ov = (sp > 32767) || (sp < -32768);
      return {ov, sp};
    end else begin
      up = {16'h0, a} * {16'h0, b};
      ov = (up > 32'h0000_FFFF);
      return {ov, up};
    end
  endfunction

  // Issue one request and wait (bounded) for done. lat counts edges after the
  // accepting edge; hs_bad counts samples with busy low before done or busy
  // high alongside done.
  task automatic do_op(input logic sm, input logic [15:0] a, input logic [15:0] b,
                       output int lat, output int hs_bad);
    @(negedge clk);
    start       = 1'b1;
    signed_mode = sm;
    A           = a;
    B           = b;
    @(posedge clk);
    #1;
    start  = 1'b0;
    lat    = 0;
    hs_bad = 0;
    while (lat < 40 && done !== 1'b1) begin
      if (busy !== 1'b1) hs_bad++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (busy !== 1'b0) hs_bad++;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    start       = 1'b0;
    signed_mode = 1'b0;
    A           = '0;
    B           = '0;
    repeat (2) @(posedge clk);
    #1;
    check({busy, done, Product, Overflow} === 35'd0,
          $sformatf("reset_outputs: got busy=%b done=%b P=%h ovf=%b, want all 0",
                    busy, done, Product, Overflow));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check(busy === 1'b0 && done === 1'b0,
          $sformatf("idle_after_reset: got busy=%b done=%b, want 0 0", busy, done));
  endtask

  task automatic test_unsigned();
    int lat, hs;
    do_op(1'b0, 16'h00FF, 16'h0101, lat, hs);
    check(lat == 17, $sformatf("u_latency: got %0d edges, want 17", lat));
    check(hs == 0, $sformatf("u_busy_window: got %0d bad busy samples, want 0", hs));
    check(Product === 32'h0000_FFFF,
          $sformatf("u_ff_x_101: got %h, want 0000ffff", Product));
    check(Overflow === 1'b0, $sformatf("u_ff_x_101_ovf: got %b, want 0", Overflow));
    @(posedge clk);
    #1;
    check(done === 1'b0,
          $sformatf("done_pulse: got done=%b one cycle later, want 0", done));

    do_op(1'b0, 16'hFFFF, 16'hFFFF, lat, hs);
    check(Product === 32'hFFFE_0001,
          $sformatf("u_max_sq: got %h, want fffe0001", Product));
    check(Overflow === 1'b1, $sformatf("u_max_sq_ovf: got %b, want 1", Overflow));
  endtask

  task automatic test_signed();
    int lat, hs;
    do_op(1'b1, 16'hFFFD, 16'h0007, lat, hs);
    check(Product === 32'hFFFF_FFEB && Overflow === 1'b0,
          $sformatf("s_m3_x_7: got %h/%b, want ffffffeb/0", Product, Overflow));
    do_op(1'b1, 16'h8000, 16'h8000, lat, hs);
    check(Product === 32'h4000_0000 && Overflow === 1'b1,
          $sformatf("s_min_sq: got %h/%b, want 40000000/1", Product, Overflow));
    do_op(1'b1, 16'h8000, 16'h0001, lat, hs);
    check(Product === 32'hFFFF_8000 && Overflow === 1'b0,
          $sformatf("s_min_x_1: got %h/%b, want ffff8000/0", Product, Overflow));
    check(lat == 17, $sformatf("s_latency: got %0d edges, want 17", lat));
  endtask

  // start held high throughout; operands change mid-operation.
  task automatic test_start_held();
    int n;
    @(negedge clk);
    start       = 1'b1;
    signed_mode = 1'b0;
    A           = 16'd3;
    B           = 16'd5;
    @(posedge clk);
    #1;
    n = 0;
    while (n < 40 && done !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 5) begin
        A = 16'd7;
        B = 16'd9;
      end
    end
    check(n == 17, $sformatf("held_latency: got %0d edges, want 17", n));
    check(Product === 32'd15,
          $sformatf("held_first_operands: got %h, want 0000000f", Product));
    @(posedge clk);
    #1;
    start = 1'b0;
    check(busy === 1'b1, $sformatf("held_reaccept: got busy=%b, want 1", busy));
    n = 0;
    while (n < 40 && done !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(n == 17 && Product === 32'd63,
          $sformatf("held_second_op: got %0d edges P=%h, want 17 0000003f", n, Product));
  endtask

  // A start issued during the done cycle is accepted immediately.
  task automatic test_back_to_back();
    int lat, hs;
    do_op(1'b0, 16'd100, 16'd200, lat, hs);
    check(Product === 32'd20000,
          $sformatf("b2b_first: got %h, want 00004e20", Product));
    do_op(1'b1, 16'hFFFF, 16'hFFFF, lat, hs);
    check(lat == 17 && hs == 0,
          $sformatf("b2b_latency: got %0d edges %0d bad busy, want 17 0", lat, hs));
    check(Product === 32'd1 && Overflow === 1'b0,
          $sformatf("b2b_second: got %h/%b, want 00000001/0", Product, Overflow));
  endtask

  task automatic test_async_reset();
    int lat, hs;
    do_op(1'b0, 16'hFFFF, 16'hFFFF, lat, hs);
    @(negedge clk);
    start       = 1'b1;
    signed_mode = 1'b0;
    A           = 16'h00FF;
    B           = 16'h0101;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check({busy, done, Product, Overflow} === 35'd0,
          $sformatf("async_reset: got busy=%b done=%b P=%h ovf=%b, want all 0",
                    busy, done, Product, Overflow));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b0, 16'h1234, 16'h0000, lat, hs);
    check(lat == 17 && Product === 32'd0 && Overflow === 1'b0,
          $sformatf("post_reset_zero: got %0d edges P=%h ovf=%b, want 17 00000000 0",
                    lat, Product, Overflow));
  endtask

  task automatic test_random();
    logic [15:0] corners [5];
    logic [15:0] a, b;
    logic [32:0] exp;
    logic        sm;
    int          lat, hs;
    corners[0] = 16'h0000;
    corners[1] = 16'h0001;
    corners[2] = 16'hFFFF;
    corners[3] = 16'h7FFF;
    corners[4] = 16'h8000;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 5; j++) begin
          sm  = (m == 1);
          exp = ref_mul(sm, corners[i], corners[j]);
          do_op(sm, corners[i], corners[j], lat, hs);
          check({Overflow, Product} === exp && lat == 17,
                $sformatf("corner s=%b %h*%h: got %h/%b in %0d, want %h/%b in 17",
                          sm, corners[i], corners[j], Product, Overflow, lat,
                          exp[31:0], exp[32]));
        end
      end
    end
    for (int k = 0; k < 600; k++) begin
      sm  = k[0];
      a   = 16'($urandom);
      b   = 16'($urandom);
      exp = ref_mul(sm, a, b);
      do_op(sm, a, b, lat, hs);
      check({Overflow, Product} === exp && lat == 17 && hs == 0,
            $sformatf("random s=%b %h*%h: got %h/%b in %0d, want %h/%b in 17",
                      sm, a, b, Product, Overflow, lat, exp[31:0], exp[32]));
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_start_held();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
